// File: rtl/counter.sv
// Wrap-around up-counter with a runtime-programmable inclusive upper bound.
// Counts MIN_VALUE..i_max and wraps to MIN_VALUE.
module counter #(
    parameter int WIDTH     = 4,
    parameter int MIN_VALUE = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_value
);

    localparam logic [WIDTH-1:0] MinVal = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    // Initialiser gives a valid count before the first reset on FPGA targets.
    logic [WIDTH-1:0] value_q = MinVal;
    logic [WIDTH-1:0] value_d;

    // Using >= keeps value_q below i_max whenever the increment is formed.
    always_comb begin
        value_d = value_q;
        if (i_enable) begin
            if (value_q >= i_max) begin
                value_d = MinVal;
            end else begin
                value_d = value_q + One;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            value_q <= MinVal;
        end else begin
            value_q <= value_d;
        end
    end

    assign o_value = value_q;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: one instance with MIN_VALUE=1,
// one with MIN_VALUE=0 for the full-range case.
module tb_counter;

    logic       clk;
    logic       rst1_n, en1;
    logic [3:0] max1, v1;
    logic       rst0_n, en0;
    logic [3:0] max0, v0;

    logic [3:0] q1[$];
    logic [3:0] q0[$];
    logic [3:0] got, exp_v;
    int         errors = 0;
    int         checks = 0;

    counter #(.WIDTH(4), .MIN_VALUE(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst1_n),
        .i_enable(en1),
        .i_max   (max1),
        .o_value (v1)
    );

    counter #(.WIDTH(4), .MIN_VALUE(0)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst0_n),
        .i_enable(en0),
        .i_max   (max0),
        .o_value (v0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick1(input logic r, input logic e,
                         input logic [3:0] m, input logic [3:0] x);
        rst1_n = r;
        en1    = e;
        max1   = m;
        q1.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic tick0(input logic r, input logic e,
                         input logic [3:0] m, input logic [3:0] x);
        rst0_n = r;
        en0    = e;
        max0   = m;
        q0.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_powerup;
        checks++;
        if (v1 !== 4'd1) begin
            errors++;
            $display("FAIL powerup1: got %0d want 1", v1);
        end
        checks++;
        if (v0 !== 4'd0) begin
            errors++;
            $display("FAIL powerup0: got %0d want 0", v0);
        end
    endtask

    task automatic test_reset;
        logic [3:0] x;
        for (int i = 0; i < 2; i++) begin
            tick1(1'b0, 1'b1, 4'd13, 4'd1);
            got = v1;
            exp_v = q1.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_hold: got %0d want %0d", got, exp_v);
            end
        end
        for (int i = 0; i < 14; i++) begin
            x = (i < 12) ? 4'(i + 2) : 4'(i - 11);
            tick1(1'b1, 1'b1, 4'd13, x);
            got = v1;
            exp_v = q1.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_count: got %0d want %0d", got, exp_v);
            end
        end
    endtask

    task automatic test_enable;
        logic [3:0] seq [8] = '{4'd3, 4'd4, 4'd5, 4'd5,
                                4'd5, 4'd5, 4'd6, 4'd7};
        logic       ens [8] = '{1'b1, 1'b1, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            tick1(1'b1, ens[i], 4'd13, seq[i]);
            got = v1;
            exp_v = q1.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL enable: got %0d want %0d", got, exp_v);
            end
        end
        // Glitches between edges must not matter.
        en1  = 1'b1;
        max1 = 4'd13;
        q1.push_back(4'd8);
        #3 en1 = 1'b0;
        max1 = 4'd2;
        #3 en1 = 1'b1;
        max1 = 4'd13;
        @(posedge clk);
        #1;
        got = v1;
        exp_v = q1.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL between_edges: got %0d want %0d", got, exp_v);
        end
    endtask

    task automatic test_bound_change;
        for (int i = 9; i <= 10; i++) begin
            tick1(1'b1, 1'b1, 4'd13, 4'(i));
            got = v1;
            exp_v = q1.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL bound_pre: got %0d want %0d", got, exp_v);
            end
        end
        for (int i = 0; i < 7; i++) begin
            tick1(1'b1, 1'b1, 4'd6, (i == 6) ? 4'd1 : 4'(i + 1));
            got = v1;
            exp_v = q1.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL bound_lower: got %0d want %0d", got, exp_v);
            end
        end
        for (int i = 2; i <= 16; i++) begin
            tick1(1'b1, 1'b1, 4'd15, (i == 16) ? 4'd1 : 4'(i));
            got = v1;
            exp_v = q1.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL bound_raise: got %0d want %0d", got, exp_v);
            end
        end
    endtask

    task automatic test_degenerate;
        for (int i = 0; i < 10; i++) begin
            tick1(1'b1, 1'b1, (i < 5) ? 4'd1 : 4'd0, 4'd1);
            got = v1;
            exp_v = q1.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL degenerate: got %0d want %0d", got, exp_v);
            end
        end
    endtask

    task automatic test_reset_priority;
        for (int i = 2; i <= 9; i++) begin
            tick1(1'b1, 1'b1, 4'd13, 4'(i));
            got = v1;
            exp_v = q1.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL prio_pre: got %0d want %0d", got, exp_v);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick1(1'b0, 1'b1, 4'd13, 4'd1);
            got = v1;
            exp_v = q1.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL prio_rst: got %0d want %0d", got, exp_v);
            end
        end
        for (int i = 2; i <= 4; i++) begin
            tick1(1'b1, 1'b1, 4'd13, 4'(i));
            got = v1;
            exp_v = q1.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL prio_resume: got %0d want %0d", got, exp_v);
            end
        end
    endtask

    task automatic test_full_range;
        tick0(1'b0, 1'b1, 4'd15, 4'd0);
        got = v0;
        exp_v = q0.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL full_rst: got %0d want %0d", got, exp_v);
        end
        for (int i = 1; i <= 17; i++) begin
            tick0(1'b1, 1'b1, 4'd15, 4'(i % 16));
            got = v0;
            exp_v = q0.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL full_range: got %0d want %0d", got, exp_v);
            end
        end
    endtask

    initial begin
        rst1_n = 1'b0;
        en1    = 1'b1;
        max1   = 4'd13;
        rst0_n = 1'b0;
        en0    = 1'b0;
        max0   = 4'd15;
        #1;
        test_powerup();
        @(posedge clk);
        #1;
        q1.delete();
        test_reset();
        test_enable();
        test_bound_change();
        test_degenerate();
        test_reset_priority();
        test_full_range();
        checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d want 0",
                     q1.size() + q0.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
